can_pkt_fifo: RTL and testbench

Parametrised packet-slot receive FIFO for the CAN controller. It is the successor to the fixed 128 x 16-byte RX buffer.
- The bit-stream side writes received frame bytes one at a time, then commits or aborts the frame.
- The host register side reads the head frame through an address window, then releases it.
- New over the previous generation: configurable slot size and depth, explicit commit/abort framing, a per-slot length field, a sticky overrun flag with explicit clear, oversize detection, and an out-of-window read that returns zero.

---
 rtl/can_fifo_pkg.sv | 26 ++
 rtl/can_fifo_ram.sv | 22 ++
 rtl/can_pkt_fifo.sv | 181 ++++++++++++++++++
 tb/tb_can_pkt_fifo.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_fifo_pkg.sv
// Shared constants and helpers for the CAN receive packet FIFO.
// Default sizing matches the previous 128 x 16-byte receive buffer.
package can_fifo_pkg;

  localparam int unsigned SLOT_LOG2_DEF  = 4;
  localparam int unsigned DEPTH_LOG2_DEF = 7;
  localparam int unsigned ADDR_W_DEF     = 6;
  localparam int unsigned BASE_EXT_DEF   = 16;
  localparam int unsigned BASE_STD_DEF   = 20;

  typedef logic [DEPTH_LOG2_DEF-1:0] slot_idx_t;
  typedef logic [SLOT_LOG2_DEF:0]    byte_ptr_t;

  // Window offset before truncation; callers keep the low ADDR_W bits.
  function automatic logic [31:0] win_offset(input logic [31:0] addr,
                                             input logic        ext,
                                             input logic [31:0] base_ext,
                                             input logic [31:0] base_std);
    return addr - (ext ? base_ext : base_std);
  endfunction

  function automatic logic is_full(input logic [31:0] cnt, input int unsigned depth_log2);
    return cnt == (32'd1 << depth_log2);
  endfunction

endpackage

// File: rtl/can_fifo_ram.sv
// Simple dual-port byte RAM: one write port, one synchronous read port.
module can_fifo_ram #(
  parameter int unsigned AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [2**AW];

  // NOTE: storage arrays carry no reset so they map onto RAM macros; every
  // consumer gates stale contents with valid state that is reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/can_pkt_fifo.sv
// Packet-slot receive FIFO: the bit-stream side fills and commits frames,
// the host side reads the head frame through an address window.
module can_pkt_fifo
  import can_fifo_pkg::*;
#(
  parameter int unsigned SLOT_LOG2  = SLOT_LOG2_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned BASE_EXT   = BASE_EXT_DEF,
  parameter int unsigned BASE_STD   = BASE_STD_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  frame_end,
  input  logic                  frame_abort,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  extended_mode,
  input  logic                  release_buffer,
  input  logic                  reset_mode,
  input  logic                  clr_overrun,
  output logic [7:0]            data_out,
  output logic                  data_out_valid,
  output logic [SLOT_LOG2:0]    head_len,
  output logic                  info_empty,
  output logic [DEPTH_LOG2:0]   info_cnt,
  output logic                  overrun,
  output logic                  oversize
);

  localparam int unsigned SLOTS  = 2**DEPTH_LOG2;
  localparam int unsigned RAM_AW = SLOT_LOG2 + DEPTH_LOG2;
  localparam logic [SLOT_LOG2:0] SLOT_BYTES = (SLOT_LOG2+1)'(2**SLOT_LOG2);

  logic [DEPTH_LOG2-1:0] wpkt_q, wpkt_d, rpkt_q, rpkt_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [SLOT_LOG2:0]    wbyte_q, wbyte_d, wbyte_nxt;
  logic                  drop_q, drop_d, drop_eff;
  logic                  overrun_q, overrun_d, oversize_q, oversize_d;
  logic                  ovr_set, osz_set;
  logic                  empty, full, commit, release_ok;
  logic [SLOT_LOG2:0]    len_q [SLOTS];

  logic                  ram_we;
  logic [RAM_AW-1:0]     ram_waddr, ram_raddr;
  logic [7:0]            ram_rdata;
  logic [ADDR_W-1:0]     offset;

  // Snapshot of everything data_out depends on, taken with the RAM read.
  logic [ADDR_W-1:0]     addr_q;
  logic                  ext_q;
  logic [DEPTH_LOG2-1:0] rdpkt_q;
  logic [SLOT_LOG2:0]    hlen_q;
  logic                  seen_q, seen_d, zero_q, zero_d;

  assign empty    = (count_q == '0);
  assign full     = is_full(32'(count_q), DEPTH_LOG2);
  assign head_len = empty ? '0 : len_q[rpkt_q];

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    wpkt_d     = wpkt_q;
    rpkt_d     = rpkt_q;
    count_d    = count_q;
    wbyte_d    = wbyte_q;
    drop_d     = drop_q;
    overrun_d  = overrun_q;
    oversize_d = oversize_q;
    wbyte_nxt  = wbyte_q;
    drop_eff   = drop_q;
    ovr_set    = 1'b0;
    osz_set    = 1'b0;
    ram_we     = 1'b0;
    commit     = 1'b0;
    release_ok = 1'b0;
    if (reset_mode) begin
      wpkt_d     = '0;
      rpkt_d     = '0;
      count_d    = '0;
      wbyte_d    = '0;
      drop_d     = 1'b0;
      overrun_d  = 1'b0;
      oversize_d = 1'b0;
    end else begin
      if (wr_en) begin
        if (wbyte_q == '0 && full) begin
          drop_eff = 1'b1;
          ovr_set  = 1'b1;
        end
        if (wbyte_q == SLOT_BYTES) begin
          osz_set = 1'b1;
        end else begin
          wbyte_nxt = wbyte_q + 1'b1;
          ram_we    = !drop_eff;
        end
      end
      // A byte arriving with the closing pulse is counted before the close.
      commit     = frame_end && !frame_abort && (wbyte_nxt != '0) && !drop_eff;
      release_ok = release_buffer && !empty;
      wbyte_d    = wbyte_nxt;
      drop_d     = drop_eff;
      if (frame_end || frame_abort) begin
        wbyte_d = '0;
        drop_d  = 1'b0;
      end
      if (commit)     wpkt_d = wpkt_q + 1'b1;
      if (release_ok) rpkt_d = rpkt_q + 1'b1;
      count_d    = count_q + (DEPTH_LOG2+1)'(commit) - (DEPTH_LOG2+1)'(release_ok);
      overrun_d  = (overrun_q  && !clr_overrun) || ovr_set;
      oversize_d = (oversize_q && !clr_overrun) || osz_set;
    end
  end

  always_comb begin
    offset    = ADDR_W'(win_offset(32'(addr), extended_mode, 32'(BASE_EXT), 32'(BASE_STD)));
    ram_raddr = {rpkt_q, offset[SLOT_LOG2-1:0]};
    ram_waddr = {wpkt_q, wbyte_q[SLOT_LOG2-1:0]};
    zero_d    = reset_mode || empty || (32'(offset) >= 32'(head_len));
    seen_d    = !reset_mode;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wpkt_q     <= '0;
      rpkt_q     <= '0;
      count_q    <= '0;
      wbyte_q    <= '0;
      drop_q     <= 1'b0;
      overrun_q  <= 1'b0;
      oversize_q <= 1'b0;
      addr_q     <= '0;
      ext_q      <= 1'b0;
      rdpkt_q    <= '0;
      hlen_q     <= '0;
      seen_q     <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      wpkt_q     <= wpkt_d;
      rpkt_q     <= rpkt_d;
      count_q    <= count_d;
      wbyte_q    <= wbyte_d;
      drop_q     <= drop_d;
      overrun_q  <= overrun_d;
      oversize_q <= oversize_d;
      addr_q     <= addr;
      ext_q      <= extended_mode;
      rdpkt_q    <= rpkt_q;
      hlen_q     <= head_len;
      seen_q     <= seen_d;
      zero_q     <= zero_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) len_q[wpkt_q] <= wbyte_nxt;
  end

  can_fifo_ram #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (wr_data),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // head_len is in the snapshot so a commit into an empty FIFO also
  // marks the output stale for one cycle.
  assign data_out_valid = seen_q && (addr == addr_q) && (extended_mode == ext_q) &&
                          (rpkt_q == rdpkt_q) && (head_len == hlen_q);
  assign data_out   = zero_q ? 8'h00 : ram_rdata;
  assign info_empty = empty;
  assign info_cnt   = count_q;
  assign overrun    = overrun_q;
  assign oversize   = oversize_q;

endmodule

// File: tb/tb_can_pkt_fifo.sv
// Randomized scoreboard bench for can_pkt_fifo against a queue-of-frames model.
module tb_can_pkt_fifo;

  localparam int DEPTH    = 128;
  localparam int SLOT     = 16;
  localparam int BASE_EXT = 16;
  localparam int BASE_STD = 20;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       wr_en = 1'b0, frame_end = 1'b0, frame_abort = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [5:0] addr = 6'd0;
  logic       extended_mode = 1'b1, release_buffer = 1'b0, reset_mode = 1'b0, clr_overrun = 1'b0;
  logic [7:0] data_out;
  logic       data_out_valid, info_empty, overrun, oversize;
  logic [4:0] head_len;
  logic [7:0] info_cnt;

  always #5 clk = ~clk;

  can_pkt_fifo dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .frame_end(frame_end), .frame_abort(frame_abort), .addr(addr),
    .extended_mode(extended_mode), .release_buffer(release_buffer),
    .reset_mode(reset_mode), .clr_overrun(clr_overrun), .data_out(data_out),
    .data_out_valid(data_out_valid), .head_len(head_len), .info_empty(info_empty),
    .info_cnt(info_cnt), .overrun(overrun), .oversize(oversize)
  );

  typedef struct packed {
    logic [4:0]       len;
    logic [15:0][7:0] b;
  } frame_t;

  frame_t     model_q[$];
  bit         m_overrun = 0, m_oversize = 0;
  logic [7:0] exp_q[$];
  int         n_checks = 0, n_fail = 0;
  logic       rd_strobe = 1'b0, rd_seen = 1'b0;
  logic [5:0] last_addr = 6'd0;
  logic       last_ext = 1'b1;
  logic [7:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: whenever a read was presented last cycle, pop and compare.
  always @(posedge clk) rd_seen <= rd_strobe;
  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rd_valid", 32'(data_out_valid), 32'd1);
        check("rd_data", 32'(data_out), 32'(mon_exp));
      end
    end
  end

  function automatic logic [4:0] m_head_len();
    return (model_q.size() == 0) ? 5'd0 : model_q[0].len;
  endfunction

  function automatic logic [7:0] exp_byte(input int a, input logic ext);
    logic [5:0] off;
    frame_t     fr;
    off = 6'((a - (ext ? BASE_EXT : BASE_STD)) & 63);
    if (model_q.size() == 0) return 8'h00;
    fr = model_q[0];
    if (off >= 6'(fr.len)) return 8'h00;
    return fr.b[off[3:0]];
  endfunction

  task automatic model_clear();
    model_q.delete();
    m_overrun  = 0;
    m_oversize = 0;
  endtask

  task automatic check_status();
    @(negedge clk);
    check("info_cnt", 32'(info_cnt), 32'(model_q.size()));
    check("info_empty", 32'(info_empty), 32'(model_q.size() == 0));
    check("head_len", 32'(head_len), 32'(m_head_len()));
    check("overrun", 32'(overrun), 32'(m_overrun));
    check("oversize", 32'(oversize), 32'(m_oversize));
    tick();
  endtask

  task automatic read_byte(input int a, input logic ext);
    bit changed;
    changed = (6'(a) != last_addr) || (ext != last_ext);
    exp_q.push_back(exp_byte(a, ext));
    addr = 6'(a);
    extended_mode = ext;
    last_addr = 6'(a);
    last_ext = ext;
    rd_strobe = 1'b1;
    @(negedge clk);
    if (changed) check("dv_low_after_change", 32'(data_out_valid), 32'd0);
    tick();
    rd_strobe = 1'b0;
    tick();
  endtask

  task automatic read_window(input logic ext);
    int len;
    len = int'(m_head_len());
    for (int off = 0; off <= len; off++) read_byte((ext ? BASE_EXT : BASE_STD) + off, ext);
  endtask

  // n bytes, then close; merge_last puts the close on the last byte's cycle.
  task automatic send_frame(input int n, input bit abort, input bit merge_last,
                            input bit rel_end, input bit rnd, input logic [7:0] v0);
    frame_t     f;
    bit         drop, was_ne, also_end;
    logic [7:0] d;
    f        = '0;
    drop     = (n > 0) && (model_q.size() == DEPTH);
    also_end = abort ? bit'($urandom_range(0, 1)) : 1'b1;
    if (drop) m_overrun = 1;
    if (n > SLOT) m_oversize = 1;
    for (int i = 0; i < n; i++) begin
      d = rnd ? 8'($urandom) : 8'(v0 + 8'(i));
      if (i < SLOT) f.b[i] = d;
      wr_en = 1'b1;
      wr_data = d;
      if (merge_last && i == n - 1) begin
        frame_end = also_end;
        frame_abort = abort;
        release_buffer = rel_end;
      end
      tick();
      wr_en = 1'b0; frame_end = 1'b0; frame_abort = 1'b0; release_buffer = 1'b0;
    end
    if (n == 0 || !merge_last) begin
      frame_end = also_end;
      frame_abort = abort;
      release_buffer = rel_end;
      tick();
      frame_end = 1'b0; frame_abort = 1'b0; release_buffer = 1'b0;
    end
    f.len  = (n > SLOT) ? 5'(SLOT) : 5'(n);
    was_ne = (model_q.size() > 0);
    if (!abort && n > 0 && !drop) model_q.push_back(f);
    if (rel_end && was_ne) void'(model_q.pop_front());
  endtask

  task automatic release_one();
    release_buffer = 1'b1;
    tick();
    release_buffer = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
  endtask

  task automatic clr();
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    m_overrun  = 0;
    m_oversize = 0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int lim;
    logic ext;
    // Reset
    repeat (3) tick();
    @(negedge clk);
    check("rst_dout_valid", 32'(data_out_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_status();

    // 1: commit and read back
    send_frame(5, 0, 0, 0, 0, 8'h11);
    check_status();
    for (int a = 16; a <= 21; a++) read_byte(a, 1'b1);
    read_byte(20, 1'b0);
    read_byte(15, 1'b1);

    // 2: abort then commit
    release_one();
    send_frame(3, 1, 0, 0, 0, 8'h77);
    send_frame(2, 0, 0, 0, 0, 8'hA0);
    check_status();
    for (int a = 16; a <= 18; a++) read_byte(a, 1'b1);

    // 3: full and overrun
    release_one();
    for (int i = 0; i < DEPTH; i++)
      send_frame($urandom_range(1, SLOT), 0, bit'($urandom_range(0, 1)), 0, 1, 8'h00);
    check_status();
    send_frame(5, 0, 0, 0, 1, 8'h00);
    check_status();
    release_one();
    read_window(1'b1);
    clr();
    check_status();
    while (model_q.size() > 0) begin
      release_one();
      if (model_q.size() % 32 == 0) check_status();
    end

    // 4: oversize
    send_frame(18, 0, 0, 0, 0, 8'h00);
    check_status();
    read_byte(31, 1'b1);
    read_byte(16, 1'b1);
    read_byte(32, 1'b1);
    clr();
    release_one();
    check_status();

    // 5: simultaneous commit/release, then wrap traffic
    for (int i = 0; i < 3; i++) send_frame($urandom_range(1, SLOT), 0, 0, 0, 1, 8'h00);
    check_status();
    send_frame(4, 0, 1, 1, 1, 8'h00);
    check_status();
    read_window(1'b1);
    for (int i = 0; i < 200; i++) begin
      send_frame($urandom_range(0, 20), ($urandom % 8) == 0, bit'($urandom_range(0, 1)),
                 (model_q.size() > 0) && (($urandom % 4) == 0), 1, 8'h00);
      if (($urandom % 3) == 0) begin
        ext = 1'($urandom_range(0, 1));
        read_byte((ext ? BASE_EXT : BASE_STD) + $urandom_range(0, 18), ext);
      end
      lim = $urandom_range(2, 6);
      while (model_q.size() > lim) release_one();
      if (i % 25 == 0) clr();
      check_status();
    end
    read_window(1'b0);

    // 6: reset_mode mid-frame
    while (model_q.size() < 2) send_frame(3, 0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      wr_data = 8'($urandom);
      tick();
    end
    wr_en = 1'b0;
    reset_mode = 1'b1;
    tick();
    reset_mode = 1'b0;
    model_clear();
    check_status();
    send_frame(1, 0, 0, 0, 0, 8'h5A);
    check_status();
    read_byte(16, 1'b1);
    read_byte(17, 1'b1);

    // 6b: asynchronous reset with four frames held
    for (int i = 0; i < 3; i++) send_frame($urandom_range(1, SLOT), 0, 0, 0, 1, 8'h00);
    check_status();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_dout_valid", 32'(data_out_valid), 32'd0);
    check("rst2_data_out", 32'(data_out), 32'd0);
    tick();
    rst_n = 1'b1;
    model_clear();
    check_status();
    send_frame(1, 0, 0, 0, 0, 8'hC3);
    check_status();
    read_byte(16, 1'b1);

    repeat (3) tick();
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
